// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, instruction SRAM drive, IF/ID bus and
// a one-entry pending-redirect buffer for branches resolved during a stall.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic [32:0] br_bus,
   output logic [32:0] if_to_id_bus,
   output logic        inst_sram_en,
   output logic [3:0]  inst_sram_wen,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   output logic [31:0] fetch_cnt
);

   typedef enum logic {ST_RESET, ST_RUN} state_t;

   state_t      state_r, state_nx;
   logic        ce_r;
   logic [31:0] pc_r, pc_nx;
   logic        pend_v, pend_v_nx;
   logic [31:0] pend_addr, pend_addr_nx;
   logic [31:0] fetch_cnt_r, fetch_cnt_nx;
   logic        br_e;
   logic [31:0] br_addr;

   assign br_e    = br_bus[32];
   assign br_addr = br_bus[31:0];
   assign ce_r    = (state_r == ST_RUN);

   always_comb begin
      state_nx     = state_r;
      pc_nx        = pc_r;
      pend_v_nx    = pend_v;
      pend_addr_nx = pend_addr;
      fetch_cnt_nx = fetch_cnt_r;
      if (ce_r && !stall[1])
         fetch_cnt_nx = fetch_cnt_r + 32'd1;
      case (state_r)
         ST_RESET: begin
            state_nx = ST_RUN;
            pc_nx    = RESET_PC;
         end
         ST_RUN: begin
            if (stall[0]) begin
               // HOLD: park the newest redirect until the PC may move again
               if (br_e) begin
                  pend_v_nx    = 1'b1;
                  pend_addr_nx = br_addr;
               end
            end else begin
               pend_v_nx = 1'b0;
               if (pend_v)
                  pc_nx = pend_addr;
               else if (br_e)
                  pc_nx = br_addr;
               else
                  pc_nx = pc_r + 32'd4;
            end
         end
         default: state_nx = ST_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_RESET;
         pc_r        <= RESET_PC - 32'd4;
         pend_v      <= 1'b0;
         pend_addr   <= '0;
         fetch_cnt_r <= '0;
      end else begin
         state_r     <= state_nx;
         pc_r        <= pc_nx;
         pend_v      <= pend_v_nx;
         pend_addr   <= pend_addr_nx;
         fetch_cnt_r <= fetch_cnt_nx;
      end
   end

   assign if_to_id_bus    = {ce_r, pc_r};
   assign inst_sram_en    = ce_r;
   assign inst_sram_wen   = '0;
   assign inst_sram_addr  = pc_r;
   assign inst_sram_wdata = '0;
   assign fetch_cnt       = fetch_cnt_r;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by randomized
// stimulus checked against a behavioural fetch model.
module tb_if_fetch;

   localparam logic [31:0] RST_PC = 32'hBFC0_0000;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic [32:0] br_bus;
   logic [32:0] if_to_id_bus;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] fetch_cnt;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] m_pc;
   logic        m_ce;
   logic        m_pv;
   logic [31:0] m_pa;
   logic [31:0] m_cnt;

   if_fetch #(.RESET_PC(RST_PC)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .br_bus          (br_bus),
      .if_to_id_bus    (if_to_id_bus),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_wen   (inst_sram_wen),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .fetch_cnt       (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model on the edge, compare after it.
   task automatic step(input logic r, input logic [5:0] s, input logic be, input logic [31:0] ba);
      rst    = r;
      stall  = s;
      br_bus = {be, ba};
      chk("stall_legal", {32'b0, ~(s[0] & ~s[1])}, 33'd1);
      @(posedge clk);
      if (r) begin
         m_pc  = RST_PC - 32'd4;
         m_ce  = 1'b0;
         m_pv  = 1'b0;
         m_pa  = 32'd0;
         m_cnt = 32'd0;
      end else begin
         if (m_ce && !s[1]) m_cnt = m_cnt + 32'd1;
         if (!m_ce) begin
            m_ce = 1'b1;
            m_pc = RST_PC;
         end else if (s[0]) begin
            if (be) begin
               m_pv = 1'b1;
               m_pa = ba;
            end
         end else begin
            m_pc = m_pv ? m_pa : (be ? ba : m_pc + 32'd4);
            m_pv = 1'b0;
         end
      end
      #1;
      chk("sram_addr", {1'b0, inst_sram_addr}, {1'b0, m_pc});
      chk("sram_en", {32'b0, inst_sram_en}, {32'b0, m_ce});
      chk("if_to_id_bus", if_to_id_bus, {m_ce, m_pc});
      chk("fetch_cnt", {1'b0, fetch_cnt}, {1'b0, m_cnt});
      chk("sram_wen_wdata", {1'b0, inst_sram_wdata | {28'b0, inst_sram_wen}}, 33'd0);
   endtask

   logic [31:0] cnt_snap;

   initial begin
      rst    = 1'b1;
      stall  = '0;
      br_bus = '0;
      m_pc = '0; m_ce = 1'b0; m_pv = 1'b0; m_pa = '0; m_cnt = '0;

      // reset state
      step(1'b1, 6'b0, 1'b0, 32'd0);
      step(1'b1, 6'b000011, 1'b1, 32'h1234_5678);
      chk("rst_addr", {1'b0, inst_sram_addr}, {1'b0, 32'hBFBF_FFFC});
      chk("rst_en", {32'b0, inst_sram_en}, 33'd0);
      chk("rst_bus", if_to_id_bus, {1'b0, 32'hBFBF_FFFC});

      // free run: first transition ignores stall/branch
      step(1'b0, 6'b000011, 1'b1, 32'h0000_4000);
      chk("run_a0", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0000});
      step(1'b0, 6'b0, 1'b0, 32'd0);
      chk("run_a1", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0004});
      step(1'b0, 6'b0, 1'b0, 32'd0);
      step(1'b0, 6'b0, 1'b0, 32'd0);
      chk("run_a3", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_000C});
      step(1'b0, 6'b0, 1'b0, 32'd0);
      chk("run_pc10", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0010});

      // branch at 0x10: delay slot forwarded, next address is target
      chk("delay_slot_bus", if_to_id_bus, {1'b1, 32'hBFC0_0010});
      step(1'b0, 6'b0, 1'b1, 32'hBFC0_0100);
      chk("br_target", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0100});

      // land at 0x20, then 3-cycle stall with a branch on cycle 2
      step(1'b0, 6'b0, 1'b1, 32'hBFC0_0020);
      cnt_snap = fetch_cnt;
      step(1'b0, 6'b000011, 1'b0, 32'd0);
      step(1'b0, 6'b000011, 1'b1, 32'hBFC0_0200);
      step(1'b0, 6'b000011, 1'b0, 32'd0);
      chk("hold_addr", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0020});
      chk("hold_en", {32'b0, inst_sram_en}, 33'd1);
      chk("hold_cnt", {1'b0, fetch_cnt}, {1'b0, cnt_snap});
      step(1'b0, 6'b0, 1'b0, 32'd0);
      chk("pend_release", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0200});

      // two pulses in one hold; pending wins over release-cycle branch
      step(1'b0, 6'b000011, 1'b1, 32'h0000_1000);
      step(1'b0, 6'b000011, 1'b0, 32'd0);
      step(1'b0, 6'b000011, 1'b1, 32'h0000_2000);
      step(1'b0, 6'b0, 1'b1, 32'h0000_3000);
      chk("pend_overwrite", {1'b0, inst_sram_addr}, {1'b0, 32'h0000_2000});
      step(1'b0, 6'b0, 1'b0, 32'd0);
      chk("pend_cleared", {1'b0, inst_sram_addr}, {1'b0, 32'h0000_2004});

      // reset during hold with a pending redirect
      step(1'b0, 6'b000011, 1'b1, 32'h0000_5000);
      step(1'b1, 6'b000011, 1'b0, 32'd0);
      step(1'b0, 6'b0, 1'b0, 32'd0);
      chk("rst_restart", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0000});
      step(1'b0, 6'b0, 1'b0, 32'd0);
      chk("rst_no_redirect", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0004});

      // PC wrap-around
      step(1'b0, 6'b0, 1'b1, 32'hFFFF_FFFC);
      step(1'b0, 6'b0, 1'b0, 32'd0);
      chk("pc_wrap", {1'b0, inst_sram_addr}, 33'd0);

      // randomized legal stimulus
      for (int i = 0; i < 400; i++) begin
         int unsigned r;
         logic [5:0]  s;
         r = $urandom_range(0, 9);
         s = (r < 6) ? 6'b000000 : (r < 9) ? 6'b000011 : 6'b000010;
         step(($urandom_range(0, 49) == 0), s, ($urandom_range(0, 3) == 0),
              {$urandom, 2'b00} >> 2 << 2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
